// File: rtl/data_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_pkg : core memory request/response types and controller states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package data_mem_ctrl_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        yumi;
    logic        valid;
    logic [31:0] read_data;
  } mem_out_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array : 32-bit register array, combinational read, byte-enabled write
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_array #(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);

  localparam int DEPTH = 1 << addr_width_p;

  // Contents are intentionally not reset so they survive a controller reset.
  logic [31:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl : single-outstanding word/byte data-memory controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    mem_o,
  output logic        err_o
);

  if (latency_p < 1 || latency_p > 15) begin : g_bad_latency
    $error("data_mem_ctrl: latency_p must be within 1..15");
  end
  if (addr_width_p < 1 || addr_width_p > 29) begin : g_bad_addr_width
    $error("data_mem_ctrl: addr_width_p must be within 1..29");
  end

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic        wen_q, bnw_q, err_q, err_d;
  logic        accept, commit, illegal;
  logic [1:0]  lane;
  logic [31:0] arr_rdata, arr_wdata;
  logic [3:0]  arr_be;
  logic [7:0]  sel_byte;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = mem_i.valid;
        if (mem_i.valid) begin
          state_d = BUSY;
          cnt_d   = 4'(latency_p - 1);
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: if (mem_i.yumi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit datapath works on the captured request, never the live inputs.
  assign lane      = addr_q[1:0];
  assign illegal   = ((addr_q >> (addr_width_p + 2)) != 32'd0) || (!bnw_q && lane != 2'd0);
  assign arr_be    = bnw_q ? (4'b0001 << lane) : 4'b1111;
  assign arr_wdata = bnw_q ? {4{wdata_q[7:0]}} : wdata_q;
  assign sel_byte  = arr_rdata[{lane, 3'b000} +: 8];

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      if (illegal || wen_q) rdata_d = 32'd0;
      else if (bnw_q)       rdata_d = {24'd0, sel_byte};
      else                  rdata_d = arr_rdata;
      if (illegal) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= addr_i;
        wdata_q <= mem_i.write_data;
        wen_q   <= mem_i.wen;
        bnw_q   <= mem_i.byte_not_word;
      end
    end
  end

  dmem_array #(
    .addr_width_p(addr_width_p)
  ) u_array (
    .clk    (clk),
    .we_i   (commit && wen_q && !illegal),
    .be_i   (arr_be),
    .addr_i (addr_q[addr_width_p+1:2]),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );

  assign mem_o.yumi      = (state_q == IDLE) && mem_i.valid;
  assign mem_o.valid     = (state_q == RESP);
  assign mem_o.read_data = rdata_q;
  assign err_o           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl : scoreboard bench for data_mem_ctrl at latency 2, 1 and 15
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int LAT [3] = '{2, 1, 15};

  logic        clk;
  logic        rst_n;
  mem_in_s     mi [3];
  mem_out_s    mo [3];
  logic [31:0] ai [3];
  logic        err [3];

  int          n_checks;
  int          n_pass;
  logic [31:0] sb [$];

  data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) u_dut (
    .clk(clk), .reset(rst_n), .mem_i(mi[0]), .addr_i(ai[0]), .mem_o(mo[0]), .err_o(err[0]));
  data_mem_ctrl #(.addr_width_p(10), .latency_p(1)) u_dut_l1 (
    .clk(clk), .reset(rst_n), .mem_i(mi[1]), .addr_i(ai[1]), .mem_o(mo[1]), .err_o(err[1]));
  data_mem_ctrl #(.addr_width_p(10), .latency_p(15)) u_dut_l15 (
    .clk(clk), .reset(rst_n), .mem_i(mi[2]), .addr_i(ai[2]), .mem_o(mo[2]), .err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // One full transaction: accept, latency, optional held-off acknowledge, release.
  task automatic do_req(input int d, input logic wen, input logic bnw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input int hold);
    int n;
    @(posedge clk); #1;
    mi[d].valid = 1'b1; mi[d].wen = wen; mi[d].byte_not_word = bnw;
    mi[d].write_data = wdata; ai[d] = addr;
    #1;
    n_checks++;
    if (mo[d].yumi !== 1'b1) $display("FAIL accept d%0d addr=%h: yumi=%b required 1", d, addr, mo[d].yumi);
    else n_pass++;
    sb.push_back(exp);
    @(posedge clk); #1;
    mi[d].valid = 1'b0;
    n = 0;
    while (mo[d].valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== LAT[d]) $display("FAIL latency d%0d addr=%h: edges=%0d required %0d", d, addr, n, LAT[d]);
    else n_pass++;
    repeat (hold) begin
      @(posedge clk); #1;
      n_checks++;
      if (mo[d].valid !== 1'b1 || mo[d].read_data !== sb[0])
        $display("FAIL hold d%0d: valid=%b data=%h required 1/%h", d, mo[d].valid, mo[d].read_data, sb[0]);
      else n_pass++;
    end
    mi[d].yumi = 1'b1;
    exp = sb.pop_front();
    n_checks++;
    if (mo[d].read_data !== exp) $display("FAIL rdata d%0d addr=%h: got %h required %h", d, addr, mo[d].read_data, exp);
    else n_pass++;
    @(posedge clk); #1;
    mi[d].yumi = 1'b0;
    n_checks++;
    if (mo[d].valid !== 1'b0) $display("FAIL release d%0d: valid=%b required 0", d, mo[d].valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mi[d] = '0; ai[d] = 32'd0;
    end
    mi[0].valid = 1'b1;
    #12;
    n_checks++;
    if (mo[0].valid !== 1'b0 || mo[0].read_data !== 32'd0 || err[0] !== 1'b0 || mo[0].yumi !== 1'b1)
      $display("FAIL reset_state: valid=%b data=%h err=%b yumi=%b required 0/0/0/1",
               mo[0].valid, mo[0].read_data, err[0], mo[0].yumi);
    else n_pass++;
    mi[0].valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    n_checks++;
    if (err[0] !== 1'b0) $display("FAIL word_err: err=%b required 0", err[0]);
    else n_pass++;
  endtask

  task automatic test_byte();
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 32'h0, 0);
    do_req(0, 1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, 32'h0, 0);
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 0);
    do_req(0, 1'b0, 1'b1, 32'h23, 32'h0, 32'h00000011, 0);
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h00000044, 0);
  endtask

  task automatic test_illegal();
    do_req(0, 1'b1, 1'b0, 32'h21, 32'hCAFEF00D, 32'h0, 0);
    n_checks++;
    if (err[0] !== 1'b1) $display("FAIL misalign_err: err=%b required 1", err[0]);
    else n_pass++;
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 0);
    do_req(0, 1'b0, 1'b0, 32'h1010, 32'h0, 32'h0, 0);
    n_checks++;
    if (err[0] !== 1'b1) $display("FAIL sticky_err: err=%b required 1", err[0]);
    else n_pass++;
  endtask

  task automatic test_delayed_ack();
    int n;
    logic [31:0] exp;
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 5);
    @(posedge clk); #1;
    mi[0].valid = 1'b1; mi[0].wen = 1'b0; mi[0].byte_not_word = 1'b0; ai[0] = 32'h20;
    sb.push_back(32'h11AA3344);
    @(posedge clk); #1;
    ai[0] = 32'h10;
    n = 0;
    while (mo[0].valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) begin
      n_checks++;
      if (mo[0].yumi !== 1'b0 || mo[0].read_data !== sb[0])
        $display("FAIL held_req: yumi=%b data=%h required 0/%h", mo[0].yumi, mo[0].read_data, sb[0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    mi[0].yumi = 1'b1;
    exp = sb.pop_front();
    n_checks++;
    if (mo[0].read_data !== exp || mo[0].yumi !== 1'b0)
      $display("FAIL ack_cycle: data=%h yumi=%b required %h/0", mo[0].read_data, mo[0].yumi, exp);
    else n_pass++;
    sb.push_back(32'hDEADBEEF);
    @(posedge clk); #1;
    mi[0].yumi = 1'b0;
    n_checks++;
    if (mo[0].yumi !== 1'b1 || mo[0].valid !== 1'b0)
      $display("FAIL reaccept: yumi=%b valid=%b required 1/0", mo[0].yumi, mo[0].valid);
    else n_pass++;
    @(posedge clk); #1;
    mi[0].valid = 1'b0;
    n = 0;
    while (mo[0].valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    exp = sb.pop_front();
    n_checks++;
    if (n !== LAT[0] || mo[0].read_data !== exp)
      $display("FAIL held_resp: edges=%0d data=%h required %0d/%h", n, mo[0].read_data, LAT[0], exp);
    else n_pass++;
    mi[0].yumi = 1'b1;
    @(posedge clk); #1;
    mi[0].yumi = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_req(0, 1'b1, 1'b0, 32'h30, 32'h55667788, 32'h0, 0);
    @(posedge clk); #1;
    mi[0].valid = 1'b1; mi[0].wen = 1'b1; mi[0].byte_not_word = 1'b0;
    mi[0].write_data = 32'hFFFFFFFF; ai[0] = 32'h30;
    @(posedge clk); #1;
    mi[0].valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mo[0].valid !== 1'b0 || mo[0].read_data !== 32'd0 || err[0] !== 1'b0 || mo[0].yumi !== 1'b0)
      $display("FAIL async_reset: valid=%b data=%h err=%b yumi=%b required 0/0/0/0",
               mo[0].valid, mo[0].read_data, err[0], mo[0].yumi);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h55667788, 0);
  endtask

  task automatic test_latency_sweep();
    for (int d = 1; d < 3; d++) begin
      do_req(d, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      do_req(d, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
      n_checks++;
      if (err[d] !== 1'b0) $display("FAIL sweep_err d%0d: err=%b required 0", d, err[d]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_word();
    test_byte();
    test_illegal();
    test_delayed_ack();
    test_reset_mid();
    test_latency_sweep();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
